// File: rtl/cam_config_seq_if.sv
// SCCB transfer handshake between the config sequencer (master) and the bus engine (slave).
interface cam_config_seq_if #(
   parameter int REG_ADDR_W = 8
);
   logic                  sccb_ready;
   logic                  sccb_start;
   logic [REG_ADDR_W-1:0] sccb_addr;
   logic [7:0]            sccb_data;
   logic                  sccb_done;
   logic                  sccb_nack;

   modport master (
      input  sccb_ready, sccb_done, sccb_nack,
      output sccb_start, sccb_addr, sccb_data
   );

   modport slave (
      output sccb_ready, sccb_done, sccb_nack,
      input  sccb_start, sccb_addr, sccb_data
   );
endinterface

// File: rtl/cam_config_seq.sv
// Camera sensor register loader: walks a ROM of {reg_addr, reg_data} words and issues SCCB writes.
// Optional macro CAM_CFG_RETRY_EN re-issues NACKed writes up to MAX_RETRY times.
module cam_config_seq #(
   parameter int CLK_FREQ   = 25000000,
   parameter int REG_ADDR_W = 8,
   parameter int ROM_AW     = 10,
   parameter int MAX_RETRY  = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic [ROM_AW-1:0]       rom_addr,
   input  logic [REG_ADDR_W+7:0]   rom_data,
   cam_config_seq_if.master        sccb,
   output logic                    busy,
   output logic                    done,
   output logic                    error,
   output logic [ROM_AW-1:0]       err_addr
);
   localparam int TICK = (CLK_FREQ >= 2000) ? CLK_FREQ / 1000 : 1;
   localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;

   typedef enum logic [2:0] {IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, DONE} state_t;

   state_t                state;
   logic                  start_q;
   logic [REG_ADDR_W-1:0] addr_q;
   logic [7:0]            data_q;
   logic [PW-1:0]         pre_cnt;
   logic [7:0]            ms_cnt;
   logic [REG_ADDR_W-1:0] w_addr;
   logic [7:0]            w_data;
   logic                  w_ctl;

`ifdef CAM_CFG_RETRY_EN
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   logic [RW-1:0]         retry_cnt;
`endif

   assign w_addr = rom_data[REG_ADDR_W+7:8];
   assign w_data = rom_data[7:0];
   assign w_ctl  = &w_addr;

   assign sccb.sccb_start = start_q;
   assign sccb.sccb_addr  = addr_q;
   assign sccb.sccb_data  = data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rom_addr <= '0;
         start_q  <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         err_addr <= '0;
         pre_cnt  <= '0;
         ms_cnt   <= '0;
`ifdef CAM_CFG_RETRY_EN
         retry_cnt <= '0;
`endif
      end else begin
         start_q <= 1'b0;
         case (state)
            IDLE: if (start) begin
               rom_addr <= '0;
               done     <= 1'b0;
               error    <= 1'b0;
               err_addr <= '0;
               busy     <= 1'b1;
`ifdef CAM_CFG_RETRY_EN
               retry_cnt <= '0;
`endif
               state    <= FETCH;
            end
            FETCH: state <= DECODE;
            DECODE: begin
               if (w_ctl && w_data == 8'hFF) begin
                  state <= DONE;
               end else if (w_ctl) begin
                  ms_cnt   <= w_data;
                  pre_cnt  <= '0;
                  rom_addr <= rom_addr + 1'b1;
                  state    <= DELAY;
               end else begin
                  addr_q <= w_addr;
                  data_q <= w_data;
                  state  <= ISSUE;
               end
            end
            ISSUE: if (sccb.sccb_ready) begin
               start_q <= 1'b1;
               state   <= WAIT;
            end
            WAIT: if (sccb.sccb_done) begin
               if (!sccb.sccb_nack) begin
`ifdef CAM_CFG_RETRY_EN
                  retry_cnt <= '0;
`endif
                  rom_addr <= rom_addr + 1'b1;
                  state    <= FETCH;
               end
`ifdef CAM_CFG_RETRY_EN
               else if (retry_cnt < RW'(MAX_RETRY)) begin
                  retry_cnt <= retry_cnt + 1'b1;
                  state     <= ISSUE;
               end
`endif
               else begin
                  error    <= 1'b1;
                  err_addr <= rom_addr;
                  state    <= DONE;
               end
            end
            // ms_cnt counts whole milliseconds left; N=0 leaves on the first cycle
            DELAY: begin
               if (ms_cnt == 8'd0) begin
                  state <= FETCH;
               end else if (pre_cnt == PW'(TICK - 1)) begin
                  pre_cnt <= '0;
                  ms_cnt  <= ms_cnt - 8'd1;
               end else begin
                  pre_cnt <= pre_cnt + 1'b1;
               end
            end
            DONE: begin
               if (!error) done <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cam_config_seq.sv
// Directed bench for cam_config_seq: transaction-level model of the expected SCCB write list and final status.
module tb_cam_config_seq;
`ifdef CAM_CFG_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif
   localparam int MAXR = 3;
   localparam int TICK = 10;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // ---------------- 8-bit address instance ----------------
   logic        start8 = 1'b0;
   logic [3:0]  rom_addr8, err_addr8;
   logic [15:0] rom_data8;
   logic        busy8, done8, error8;
   logic [15:0] rom8 [16];
   cam_config_seq_if #(.REG_ADDR_W(8)) bus8 ();

   cam_config_seq #(.CLK_FREQ(TICK * 1000), .REG_ADDR_W(8), .ROM_AW(4), .MAX_RETRY(MAXR)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .rom_addr(rom_addr8), .rom_data(rom_data8),
      .sccb(bus8.master), .busy(busy8), .done(done8), .error(error8), .err_addr(err_addr8));

   always @(posedge clk) rom_data8 <= rom8[rom_addr8];

   // SCCB engine: 3-cycle transfers, ACKs the first ack_skip, then NACKs nack_cnt
   int   s_cnt, xfer_n, ack_skip = 0, nack_cnt = 0;
   logic ready_block = 1'b0;
   assign bus8.sccb_ready = !ready_block && (s_cnt == 0);
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_cnt <= 0; xfer_n <= 0; bus8.sccb_done <= 1'b0; bus8.sccb_nack <= 1'b0;
      end else begin
         bus8.sccb_done <= 1'b0;
         bus8.sccb_nack <= 1'b0;
         if (s_cnt == 1) begin
            bus8.sccb_done <= 1'b1;
            bus8.sccb_nack <= (xfer_n >= ack_skip) && (xfer_n < ack_skip + nack_cnt);
            xfer_n <= xfer_n + 1;
         end
         if (s_cnt > 0) s_cnt <= s_cnt - 1;
         else if (bus8.sccb_start) s_cnt <= 3;
         if (start8 && !busy8) xfer_n <= 0;
      end
   end

   // Model: expected writes and final status derived from ROM contents and NACK schedule
   logic [15:0] exp_q [$];
   bit          exp_err;
   logic [3:0]  exp_eaddr;
   task automatic build_exp(input int skip, input int nacks);
      int idx = 0, r = 0, n_ok = skip, n_bad = nacks;
      logic [15:0] w;
      exp_q.delete(); exp_err = 0; exp_eaddr = 0;
      for (int g = 0; g < 64; g++) begin
         w = rom8[idx];
         if (w[15:8] == 8'hFF) begin
            if (w[7:0] == 8'hFF) return;
            idx = (idx + 1) % 16;
            continue;
         end
         exp_q.push_back(w);
         if (n_ok > 0) n_ok--;
         else if (n_bad > 0) begin
            n_bad--;
            if (RETRY && r < MAXR) begin r++; continue; end
            exp_err = 1; exp_eaddr = 4'(idx);
            return;
         end
         r = 0;
         idx = (idx + 1) % 16;
      end
   endtask

   // Per-cycle compare: every sccb_start must match the next modelled write, be one cycle, and hold its word
   int          n_wr = 0;
   int          wr_cyc [$];
   logic [15:0] held;
   bit          outst = 0, prev_start = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         outst = 0; prev_start = 0;
      end else begin
         if (bus8.sccb_start) begin
            chk("start_one_cycle", 32'(prev_start), 32'd0);
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_write: got %0h want none", {bus8.sccb_addr, bus8.sccb_data});
            end else chk("write_word", {bus8.sccb_addr, bus8.sccb_data}, exp_q.pop_front());
            n_wr++; wr_cyc.push_back(cyc);
            held = {bus8.sccb_addr, bus8.sccb_data}; outst = 1;
         end else if (outst) chk("word_hold", {bus8.sccb_addr, bus8.sccb_data}, held);
         if (bus8.sccb_done) outst = 0;
         prev_start = bus8.sccb_start;
      end
   end

   // ---------------- 16-bit address instance ----------------
   logic        start16 = 1'b0;
   logic [3:0]  rom_addr16, err_addr16;
   logic [23:0] rom_data16;
   logic        busy16, done16, error16;
   logic [23:0] rom16 [16];
   cam_config_seq_if #(.REG_ADDR_W(16)) bus16 ();

   cam_config_seq #(.CLK_FREQ(TICK * 1000), .REG_ADDR_W(16), .ROM_AW(4), .MAX_RETRY(MAXR)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .rom_addr(rom_addr16), .rom_data(rom_data16),
      .sccb(bus16.master), .busy(busy16), .done(done16), .error(error16), .err_addr(err_addr16));

   always @(posedge clk) rom_data16 <= rom16[rom_addr16];

   int          t_cnt, n_wr16 = 0;
   logic [23:0] cap16 = '0;
   assign bus16.sccb_ready = (t_cnt == 0);
   assign bus16.sccb_nack  = 1'b0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_cnt <= 0; bus16.sccb_done <= 1'b0;
      end else begin
         bus16.sccb_done <= (t_cnt == 1);
         if (t_cnt > 0) t_cnt <= t_cnt - 1;
         else if (bus16.sccb_start) t_cnt <= 2;
      end
   end
   always @(negedge clk) if (rst_n && bus16.sccb_start) begin
      cap16 = {bus16.sccb_addr, bus16.sccb_data};
      n_wr16++;
   end

   // ---------------- stimulus ----------------
   task automatic load8(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
      for (int i = 0; i < 16; i++) rom8[i] = 16'hFFFF;
      rom8[0] = a; rom8[1] = b; rom8[2] = c; rom8[3] = d;
   endtask

   task automatic pulse_start8();
      @(negedge clk) start8 = 1'b1;
      @(negedge clk) start8 = 1'b0;
   endtask

   task automatic wait_fin(input string nm);
      int k;
      for (k = 0; k < 2000; k++) begin
         @(negedge clk);
         if (done8 || error8) break;
      end
      if (k == 2000) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: got no done/error want finish within 2000 cycles", nm);
      end
   endtask

   task automatic final_chk(input string nm);
      repeat (20) @(negedge clk);
      chk({nm, "_busy"}, 32'(busy8), 32'd0);
      chk({nm, "_done"}, 32'(done8), 32'(!exp_err));
      chk({nm, "_error"}, 32'(error8), 32'(exp_err));
      if (exp_err) chk({nm, "_err_addr"}, 32'(err_addr8), 32'(exp_eaddr));
      chk({nm, "_writes_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic reset_chk(input string nm);
      chk({nm, "_rom_addr"}, 32'(rom_addr8), 32'd0);
      chk({nm, "_sccb_start"}, 32'(bus8.sccb_start), 32'd0);
      chk({nm, "_sccb_addr"}, 32'(bus8.sccb_addr), 32'd0);
      chk({nm, "_sccb_data"}, 32'(bus8.sccb_data), 32'd0);
      chk({nm, "_busy"}, 32'(busy8), 32'd0);
      chk({nm, "_done"}, 32'(done8), 32'd0);
      chk({nm, "_error"}, 32'(error8), 32'd0);
      chk({nm, "_err_addr"}, 32'(err_addr8), 32'd0);
   endtask

   initial begin
      int gap, k;
      load8(16'h1280, 16'hFF0A, 16'h1101, 16'hFFFF);
      for (int i = 0; i < 16; i++) rom16[i] = 24'hFFFFFF;
      rom16[0] = 24'h300882;

      // reset state
      repeat (3) @(negedge clk);
      reset_chk("rst");
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_start", 32'(bus8.sccb_start), 32'd0);

      // two writes separated by a 10 ms delay
      build_exp(0, 0);
      chk("model_len", 32'(exp_q.size()), 32'd2);
      chk("model_w0", 32'(exp_q[0]), 32'h1280);
      chk("model_w1", 32'(exp_q[1]), 32'h1101);
      n_wr = 0; wr_cyc.delete();
      pulse_start8();
      chk("busy_after_start", 32'(busy8), 32'd1);
      wait_fin("seq");
      final_chk("seq");
      chk("seq_writes", 32'(n_wr), 32'd2);
      gap = (wr_cyc.size() >= 2) ? wr_cyc[1] - wr_cyc[0] : 0;
      chk("delay_gap_ge_10ms", 32'(gap >= 10 * TICK), 32'd1);

      // sccb_ready low for 50 cycles; a start while busy is ignored
      build_exp(0, 0);
      n_wr = 0; ready_block = 1'b1;
      pulse_start8();
      repeat (10) @(negedge clk);
      pulse_start8();
      repeat (40) @(negedge clk);
      chk("no_start_while_not_ready", 32'(n_wr), 32'd0);
      @(negedge clk) ready_block = 1'b0;
      wait_fin("ready");
      final_chk("ready");
      chk("ready_writes", 32'(n_wr), 32'd2);

      // NACK twice on word 1, then ACK
      load8(16'h1280, 16'h1101, 16'hFFFF, 16'hFFFF);
      ack_skip = 1; nack_cnt = 2;
      build_exp(1, 2);
      chk("model_nack2_len", 32'(exp_q.size()), RETRY ? 32'd4 : 32'd2);
      chk("model_nack2_err", 32'(exp_err), RETRY ? 32'd0 : 32'd1);
      n_wr = 0;
      pulse_start8();
      wait_fin("nack2");
      final_chk("nack2");
      chk("nack2_writes", 32'(n_wr), RETRY ? 32'd4 : 32'd2);

      // NACK four times on word 1: unrecovered
      nack_cnt = 4;
      build_exp(1, 4);
      chk("model_nack4_err", 32'(exp_err), 32'd1);
      chk("model_nack4_eaddr", 32'(exp_eaddr), 32'd1);
      n_wr = 0;
      pulse_start8();
      wait_fin("nack4");
      final_chk("nack4");
      chk("nack4_err_addr_lit", 32'(err_addr8), 32'd1);
      chk("nack4_writes", 32'(n_wr), RETRY ? 32'd5 : 32'd2);
      ack_skip = 0; nack_cnt = 0;

      // reset pulsed while in DELAY, then rerun from word 0
      load8(16'h1280, 16'hFF0A, 16'h1101, 16'hFFFF);
      build_exp(0, 0);
      n_wr = 0;
      pulse_start8();
      for (k = 0; k < 200 && n_wr < 1; k++) @(negedge clk);
      chk("dly_first_write_seen", 32'(n_wr), 32'd1);
      repeat (20) @(negedge clk);
      chk("dly_rom_addr", 32'(rom_addr8), 32'd2);
      chk("dly_busy", 32'(busy8), 32'd1);
      rst_n = 1'b0;
      #1;
      reset_chk("midrst");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_release_start", 32'(bus8.sccb_start), 32'd0);
      reset_chk("midrst_idle");
      build_exp(0, 0);
      n_wr = 0;
      pulse_start8();
      wait_fin("rerun");
      final_chk("rerun");
      chk("rerun_writes", 32'(n_wr), 32'd2);

      // 16-bit register addresses
      @(negedge clk) start16 = 1'b1;
      @(negedge clk) start16 = 1'b0;
      for (k = 0; k < 500 && !done16 && !error16; k++) @(negedge clk);
      chk("a16_finished", 32'(done16 | error16), 32'd1);
      chk("a16_word", 32'(cap16), 32'h300882);
      chk("a16_writes", 32'(n_wr16), 32'd1);
      chk("a16_done", 32'(done16), 32'd1);
      chk("a16_error", 32'(error16), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/cam_config_seq.md
CAM_CONFIG_SEQ -- requirements
Module: cam_config_seq

Interface
REQ-001 Parameter CLK_FREQ, default 25000000, clock frequency in Hz; sets the 1 ms tick (CLK_FREQ/1000 cycles).
REQ-002 Parameter REG_ADDR_W, default 8, sensor register address width; legal values 8 or 16.
REQ-003 Parameter ROM_AW, default 10, ROM address width.
REQ-004 Parameter MAX_RETRY, default 3, number of re-issues allowed per NACKed write.
REQ-005 clk  in  1  system clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 start  in  1  single-cycle request to run the sequence; honoured only in IDLE.
REQ-008 rom_addr  out  ROM_AW  address to the synchronous ROM.
REQ-009 rom_data  in  REG_ADDR_W+8  ROM word {reg_addr, reg_data}, valid one cycle after rom_addr changes.
REQ-010 sccb_ready  in  1  bus master idle and able to accept a transfer.
REQ-011 sccb_start  out  1  one-cycle transfer request.
REQ-012 sccb_addr  out  REG_ADDR_W  register address, held stable from sccb_start until sccb_done.
REQ-013 sccb_data  out  8  register data, held stable with sccb_addr.
REQ-014 sccb_done  in  1  one-cycle pulse: transfer finished.
REQ-015 sccb_nack  in  1  sampled with sccb_done; 1 = slave did not acknowledge.
REQ-016 busy  out  1  high from the start accept cycle until DONE is exited.
REQ-017 done  out  1  sticky; set on sequence end, cleared on next accepted start.
REQ-018 error  out  1  sticky; set on unrecovered NACK, cleared on next accepted start.
REQ-019 err_addr  out  ROM_AW  ROM index of the failing word; valid while error=1.

Function
REQ-020 States: IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, DONE.
REQ-021 IDLE: start=1 -> rom_addr=0, clear done, error and retry count, go FETCH.
REQ-022 FETCH: one-cycle wait for ROM latency -> DECODE.
REQ-023 DECODE, reg_addr all ones and reg_data=8'hFF: end marker -> DONE.
REQ-024 DECODE, reg_addr all ones and reg_data=N, N not 8'hFF: delay N ms (N=0 gives no delay); rom_addr+1 -> DELAY.
REQ-025 DECODE, any other word: latch sccb_addr and sccb_data -> ISSUE.
REQ-026 ISSUE: when sccb_ready=1, pulse sccb_start for exactly one cycle -> WAIT; otherwise hold in ISSUE.
REQ-027 WAIT, sccb_done=1 and sccb_nack=0: clear retry count, rom_addr+1 -> FETCH.
REQ-028 WAIT, sccb_done=1 and sccb_nack=1: handled per REQ-036/REQ-037.
REQ-029 DELAY: 1 ms prescaler plus 8-bit ms down-counter; on expiry -> FETCH; with N=0 exits after one cycle.
REQ-030 DONE: set done, or set error when entered on failure; -> IDLE next cycle.
REQ-031 start while busy=1 is ignored and produces no state change.
REQ-032 rom_addr at its maximum with no end marker: wraps to 0 and continues; the ROM content must contain an end marker.
REQ-033 sccb_done outside WAIT is ignored.

Reset
REQ-034 rst_n=0 forces state IDLE and these outputs: rom_addr=0, sccb_start=0, sccb_addr=0, sccb_data=0, busy=0, done=0, error=0, err_addr=0; timers and retry count=0.
REQ-035 Reset mid-sequence aborts immediately; sccb_start is never asserted during or in the first cycle after reset release.

Configuration
REQ-036 Macro CAM_CFG_RETRY_EN defined: a NACK with retry count < MAX_RETRY increments the count and returns to ISSUE with the same word; a NACK at MAX_RETRY sets error, sets err_addr=rom_addr and goes to DONE.
REQ-037 Macro CAM_CFG_RETRY_EN undefined: the first NACK sets error, sets err_addr=rom_addr and goes to DONE; the MAX_RETRY parameter has no effect.

Verification
REQ-038 ROM {0x12_80, 0xFF_0A, 0x11_01, 0xFF_FF}, all ACK -> 2 writes in order; gap of >=10*CLK_FREQ/1000 cycles between them; done=1, busy=0, error=0.
REQ-039 sccb_ready held low for 50 cycles during ISSUE -> sccb_start waits, then asserts for exactly 1 cycle once ready=1.
REQ-040 With CAM_CFG_RETRY_EN, NACK on word 1 twice and then ACK -> 3 identical transfers, sequence completes, error=0.
REQ-041 With CAM_CFG_RETRY_EN undefined, or with NACK 4 times in a row when MAX_RETRY=3 -> error=1, err_addr=1, done=0, no further writes.
REQ-042 rst_n pulsed low during DELAY -> IDLE with all outputs at their reset values; a following start reruns the sequence from rom_addr 0.
REQ-043 REG_ADDR_W=16, ROM {0x3008_82, 0xFFFF_FF} -> sccb_addr=0x3008, sccb_data=0x82, then done=1.
